// File: rtl/text_stream_tx.sv
`default_nettype none
// ============================================================================
//  Module      : text_stream_tx
//  Description : Buffers one text message written a character at a time and,
//                on start, replays it as a valid/ready stream with first/last
//                framing toward the tokenizer's character input.
//  Revision    : 1.0 - initial release
// ============================================================================
module text_stream_tx #(
    parameter int CHAR_W    = 32,
    parameter int MAX_CHARS = 160,
    parameter int LEN_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [CHAR_W-1:0] wr_data,
    output logic              wr_full,
    output logic [LEN_W-1:0]  char_count,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [CHAR_W-1:0] tx_data,
    output logic              tx_first,
    output logic              tx_last
);

    localparam logic [LEN_W-1:0] C_MAX_CNT = LEN_W'(MAX_CHARS);
    localparam logic [LEN_W-1:0] C_ONE     = LEN_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [LEN_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LEN_W-1:0]   count_q, count_d;
    logic               w_mem_we;
    logic [CHAR_W-1:0]  mem [MAX_CHARS];

    // Next-state logic: append in IDLE, advance on handshakes in SEND, clear in DONE
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        w_mem_we = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // The write is resolved before start so a same-cycle start sees the new count
                if (wr_en && (count_q < C_MAX_CNT)) begin
                    w_mem_we = 1'b1;
                    wr_ptr_d = wr_ptr_q + C_ONE;
                    count_d  = count_q + C_ONE;
                end
                if (start) begin
                    rd_ptr_d = '0;
                    state_d  = (count_d != '0) ? ST_SEND : ST_DONE;
                end
            end
            ST_SEND: begin
                if (tx_ready) begin
                    if ((rd_ptr_q + C_ONE) == count_q) begin
                        state_d = ST_DONE;
                    end else begin
                        rd_ptr_d = rd_ptr_q + C_ONE;
                    end
                end
            end
            ST_DONE: begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                count_d  = '0;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state and pointers; reset aborts any transfer and discards the message
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Character storage, deliberately left unreset
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    // Outputs are decoded purely from registered state, so they are glitch-free
    // and stay stable while a beat is stalled
    always_comb begin
        busy       = (state_q != ST_IDLE);
        done       = (state_q == ST_DONE);
        tx_valid   = (state_q == ST_SEND);
        tx_data    = tx_valid ? mem[rd_ptr_q] : '0;
        tx_first   = tx_valid && (rd_ptr_q == '0);
        tx_last    = tx_valid && ((rd_ptr_q + C_ONE) == count_q);
        wr_full    = (count_q == C_MAX_CNT);
        char_count = count_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_text_stream_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_text_stream_tx
//  Description : Self-checking bench for text_stream_tx using fixed vectors,
//                directed corner sequences and a queue-based message model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_text_stream_tx;

    localparam int MAX_CHARS = 160;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        start;
    logic        tx_ready;
    logic        wr_full;
    logic [7:0]  char_count;
    logic        busy;
    logic        done;
    logic        tx_valid;
    logic [31:0] tx_data;
    logic        tx_first;
    logic        tx_last;

    int errors = 0;
    int checks = 0;

    // Reference model: the buffered message, the index being offered, and phase flags
    logic [31:0] m_buf[$];
    int          m_idx;
    bit          m_send;
    bit          m_done;

    // Handshakes seen: {first, last, data}
    logic [33:0] beat_log[$];

    text_stream_tx #(.CHAR_W(32), .MAX_CHARS(160), .LEN_W(8)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .wr_full(wr_full), .char_count(char_count), .start(start),
        .busy(busy), .done(done), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_data(tx_data), .tx_first(tx_first), .tx_last(tx_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] d;
        logic        st;
        logic        rdy;
        logic        e_valid;
        logic [31:0] e_data;
        logic        e_first;
        logic        e_last;
        logic        e_done;
        logic [7:0]  e_count;
    } vec_t;

    vec_t tbl[13];

    function automatic logic [45:0] model_out();
        logic        v;
        logic [31:0] d;
        v = m_send;
        d = v ? m_buf[m_idx] : 32'd0;
        return {m_send | m_done, m_done, v, v && (m_idx == 0),
                v && (m_idx == m_buf.size() - 1),
                m_buf.size() == MAX_CHARS, 8'(m_buf.size()), d};
    endfunction

    function automatic logic [45:0] dut_out();
        return {busy, done, tx_valid, tx_first, tx_last, wr_full, char_count, tx_data};
    endfunction

    task automatic model_reset();
        m_buf.delete();
        m_idx  = 0;
        m_send = 0;
        m_done = 0;
    endtask

    // Advance the model by one clock using the inputs applied for that edge
    task automatic model_step();
        if (m_done) begin
            m_done = 0;
            m_buf.delete();
            m_idx = 0;
        end else if (m_send) begin
            if (tx_ready) begin
                if (m_idx == m_buf.size() - 1) begin
                    m_send = 0;
                    m_done = 1;
                end else begin
                    m_idx++;
                end
            end
        end else begin
            if (wr_en && m_buf.size() < MAX_CHARS) m_buf.push_back(wr_data);
            if (start) begin
                if (m_buf.size() > 0) begin
                    m_send = 1;
                    m_idx  = 0;
                end else begin
                    m_done = 1;
                end
            end
        end
    endtask

    task automatic check_model(input string name);
        logic [45:0] e;
        logic [45:0] a;
        e = model_out();
        a = dut_out();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got busy/done/valid/first/last/full=%b count=%0d data=%h, expected %b count=%0d data=%h",
                     name, a[45:40], a[39:32], a[31:0], e[45:40], e[39:32], e[31:0]);
        end
    endtask

    task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // One clock: drive inputs, log any handshake, clock, update model, compare
    task automatic cycle(input logic we, input logic [31:0] d, input logic st,
                         input logic rdy, input string name);
        wr_en    = we;
        wr_data  = d;
        start    = st;
        tx_ready = rdy;
        #1;
        if (tx_valid && tx_ready) beat_log.push_back({tx_first, tx_last, tx_data});
        @(posedge clk);
        #1;
        model_step();
        check_model(name);
    endtask

    task automatic idle_inputs();
        wr_en    = 1'b0;
        wr_data  = 32'd0;
        start    = 1'b0;
        tx_ready = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int n = 0; n < 400 && (m_send || m_done); n++) begin
            cycle(1'b0, 32'd0, 1'b0, 1'b1, name);
        end
        check_val({name, "_timeout"}, 64'(m_send || m_done), 64'd0);
    endtask

    initial begin
        // Vectors: 3-character message at full rate, then a 1-character message
        tbl[0]  = '{1, 32'h61, 0, 0,  0, 0,     0, 0, 0, 8'd1};
        tbl[1]  = '{1, 32'h62, 0, 0,  0, 0,     0, 0, 0, 8'd2};
        tbl[2]  = '{1, 32'h63, 0, 0,  0, 0,     0, 0, 0, 8'd3};
        tbl[3]  = '{0, 0,      1, 1,  1, 32'h61, 1, 0, 0, 8'd3};
        tbl[4]  = '{0, 0,      0, 1,  1, 32'h62, 0, 0, 0, 8'd3};
        tbl[5]  = '{0, 0,      0, 1,  1, 32'h63, 0, 1, 0, 8'd3};
        tbl[6]  = '{0, 0,      0, 1,  0, 0,     0, 0, 1, 8'd3};
        tbl[7]  = '{0, 0,      0, 1,  0, 0,     0, 0, 0, 8'd0};
        tbl[8]  = '{1, 32'h41, 0, 0,  0, 0,     0, 0, 0, 8'd1};
        tbl[9]  = '{0, 0,      1, 0,  1, 32'h41, 1, 1, 0, 8'd1};
        tbl[10] = '{1, 32'h55, 1, 0,  1, 32'h41, 1, 1, 0, 8'd1};
        tbl[11] = '{0, 0,      0, 1,  0, 0,     0, 0, 1, 8'd1};
        tbl[12] = '{0, 0,      0, 0,  0, 0,     0, 0, 0, 8'd0};

        idle_inputs();
        reset = 1'b1;
        model_reset();
        #1;
        check_val("reset_outputs", 64'(dut_out()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Fixed vectors
        for (int i = 0; i < 13; i++) begin
            cycle(tbl[i].we, tbl[i].d, tbl[i].st, tbl[i].rdy, $sformatf("tbl_model[%0d]", i));
            checks++;
            if ({tx_valid, tx_data, tx_first, tx_last, done, char_count} !==
                {tbl[i].e_valid, tbl[i].e_data, tbl[i].e_first, tbl[i].e_last, tbl[i].e_done, tbl[i].e_count}) begin
                errors++;
                $display("FAIL tbl[%0d]: got valid=%b data=%h first=%b last=%b done=%b count=%0d, expected valid=%b data=%h first=%b last=%b done=%b count=%0d",
                         i, tx_valid, tx_data, tx_first, tx_last, done, char_count,
                         tbl[i].e_valid, tbl[i].e_data, tbl[i].e_first, tbl[i].e_last, tbl[i].e_done, tbl[i].e_count);
            end
        end

        // Backpressure on the second beat
        beat_log.delete();
        cycle(1, 32'h61, 0, 0, "bp_wr");
        cycle(1, 32'h62, 0, 0, "bp_wr");
        cycle(1, 32'h63, 0, 0, "bp_wr");
        cycle(0, 0, 1, 0, "bp_start");
        cycle(0, 0, 0, 1, "bp_beat1");
        for (int k = 0; k < 4; k++) begin
            cycle(0, 0, 0, 0, "bp_stall");
            check_val("bp_hold_data", 64'(tx_data), 64'h62);
        end
        wait_idle("bp_drain");
        check_val("bp_beats", 64'(beat_log.size()), 64'd3);
        if (beat_log.size() == 3) begin
            check_val("bp_seq", {beat_log[0][31:0], beat_log[1][31:0]}, {32'h61, 32'h62});
            check_val("bp_seq_last", 64'(beat_log[2]), 64'({2'b01, 32'h63}));
        end

        // Fill past capacity; the extra character is dropped
        beat_log.delete();
        for (int v = 0; v <= 160; v++) begin
            cycle(1, 32'(v), 0, 0, "fill_wr");
            if (v == 159) check_val("full_at_160", 64'({wr_full, char_count}), 64'({1'b1, 8'd160}));
            if (v == 158) check_val("not_full_159", 64'(wr_full), 64'd0);
        end
        check_val("full_drop", 64'(char_count), 64'd160);
        cycle(0, 0, 1, 1, "fill_start");
        wait_idle("fill_drain");
        check_val("fill_beats", 64'(beat_log.size()), 64'd160);
        if (beat_log.size() == 160) begin
            check_val("fill_first", 64'(beat_log[0]), 64'({2'b10, 32'd0}));
            check_val("fill_last", 64'(beat_log[159]), 64'({2'b01, 32'd159}));
        end

        // Empty start: done one cycle later, never valid
        cycle(0, 0, 1, 1, "empty_start");
        check_val("empty_done", 64'({done, tx_valid}), 64'b10);
        cycle(0, 0, 0, 1, "empty_after");
        check_val("empty_idle", 64'({done, busy, tx_valid}), 64'd0);

        // Reset in the middle of a 5-character message
        for (int v = 0; v < 5; v++) cycle(1, 32'h10 + 32'(v), 0, 0, "rst_wr");
        cycle(0, 0, 1, 1, "rst_start");
        cycle(0, 0, 0, 1, "rst_beat2");
        check_val("rst_pre_data", 64'(tx_data), 64'h11);
        reset = 1'b1;
        #1;
        model_reset();
        check_val("rst_async_outputs", 64'(dut_out()), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 3; k++) cycle(0, 0, 0, 1, "rst_no_done");
        beat_log.delete();
        cycle(1, 32'h21, 0, 0, "rst_new_wr");
        cycle(1, 32'h22, 1, 0, "rst_new_wr_start");
        wait_idle("rst_new_drain");
        check_val("rst_new_beats", 64'(beat_log.size()), 64'd2);
        if (beat_log.size() == 2) begin
            check_val("rst_new_seq", {30'd0, beat_log[0], beat_log[1][31:0]},
                      {30'd0, 2'b10, 32'h21, 32'h22});
            check_val("rst_new_last", 64'(beat_log[1][33:32]), 64'b01);
        end

        // Random messages against the model, with garbage writes/starts while sending
        for (int m = 0; m < 30; m++) begin
            int len;
            len = $urandom_range(0, 12);
            for (int c = 0; c < len; c++) begin
                if ($urandom_range(0, 3) == 0) cycle(0, $urandom, 0, $urandom_range(0, 1), "rnd_gap");
                cycle(1, $urandom, 0, $urandom_range(0, 1), "rnd_wr");
            end
            cycle($urandom_range(0, 1), $urandom, 1, $urandom_range(0, 1), "rnd_start");
            for (int n = 0; n < 300 && (m_send || m_done); n++) begin
                cycle($urandom_range(0, 1), $urandom, $urandom_range(0, 1),
                      $urandom_range(0, 9) < 7, "rnd_send");
            end
            check_val("rnd_timeout", 64'(m_send || m_done), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
